// File: rtl/hash_pkg.sv
// Shared constants for the multiply-shift hash pipeline: default odd seeds
// and the table-index width helper.
package hash_pkg;

    localparam int MAX_HASHES = 8;

    // Odd multipliers; only the low KEY_WIDTH bits are used by a given build.
    localparam logic [63:0] DEFAULT_SEEDS [MAX_HASHES] = '{
        64'h0000_0000_9E37_79B1,
        64'h0000_0000_85EB_CA6B,
        64'h0000_0000_C2B2_AE35,
        64'h0000_0000_27D4_EB2F,
        64'h0000_0000_1656_67B1,
        64'h0000_0000_D3A2_646D,
        64'h0000_0000_FD70_46C5,
        64'h0000_0000_B55A_4F09
    };

    function automatic int hash_width(input int num_entries);
        return $clog2(num_entries);
    endfunction

endpackage

// File: rtl/mult_shift_hash.sv
// One hash lane: registered truncated product of key and seed, then the
// registered top HASH_WIDTH bits of that product.
module mult_shift_hash #(
    parameter int KEY_WIDTH  = 32,
    parameter int HASH_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en_p1,
    input  logic                  en_p2,
    input  logic [KEY_WIDTH-1:0]  key_p0,
    input  logic [KEY_WIDTH-1:0]  seed,
    output logic [HASH_WIDTH-1:0] hash_p2
);

    logic [KEY_WIDTH-1:0] prod_p1;

    function automatic logic [HASH_WIDTH-1:0] extract_hash(input logic [KEY_WIDTH-1:0] prod);
        return HASH_WIDTH'(prod >> (KEY_WIDTH - HASH_WIDTH));
    endfunction

    // Stage p1: product mod 2^KEY_WIDTH
    always_ff @(posedge clock) begin
        if (en_p1) begin
            prod_p1 <= key_p0 * seed;
        end
    end

    // Stage p2: extracted hash, cleared on reset so the output is defined
    always_ff @(posedge clock) begin
        if (reset) begin
            hash_p2 <= '0;
        end else if (en_p2) begin
            hash_p2 <= extract_hash(prod_p1);
        end
    end

endmodule

// File: rtl/multi_hash_pipe.sv
// Three-stage multiply-shift hash pipeline computing NUM_HASHES independent
// table indices per key, with writable odd seeds and valid/ready handshakes.
module multi_hash_pipe
    import hash_pkg::*;
#(
    parameter int NUM_ENTRIES_PER_HASH_TABLE = 256,
    parameter int NUM_HASHES                 = 2,
    parameter int KEY_WIDTH                  = 32,
    parameter int TAG_WIDTH                  = 8,
    localparam int HASH_WIDTH                = hash_width(NUM_ENTRIES_PER_HASH_TABLE),
    localparam int SEED_IDX_WIDTH            = (NUM_HASHES > 1) ? $clog2(NUM_HASHES) : 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [KEY_WIDTH-1:0]             in_key,
    input  logic [TAG_WIDTH-1:0]             in_tag,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_HASHES*HASH_WIDTH-1:0] out_hash,
    output logic [TAG_WIDTH-1:0]             out_tag,
    input  logic                             seed_we,
    input  logic [SEED_IDX_WIDTH-1:0]        seed_idx,
    input  logic [KEY_WIDTH-1:0]             seed_data,
    output logic                             seed_ready
);

    logic                 vld_p0, vld_p1, vld_p2;
    logic                 en_p0, en_p1, en_p2;
    logic                 stall, accept;
    logic [KEY_WIDTH-1:0] key_p0;
    logic [TAG_WIDTH-1:0] tag_p0, tag_p1, tag_p2;
    logic [KEY_WIDTH-1:0] seed_q [NUM_HASHES];

    // A stage may load whenever it is empty or its contents move on, so
    // bubbles collapse even while the output is held.
    assign stall      = vld_p2 && !out_ready;
    assign en_p2      = !vld_p2 || out_ready;
    assign en_p1      = !vld_p1 || en_p2;
    assign en_p0      = !vld_p0 || en_p1;
    assign in_ready   = !stall && !seed_we;
    assign accept     = in_valid && in_ready;
    assign seed_ready = !vld_p0 && !vld_p1 && !vld_p2;

    assign out_valid  = vld_p2;
    assign out_tag    = tag_p2;

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (en_p0) vld_p0 <= accept;
            if (en_p1) vld_p1 <= vld_p0;
            if (en_p2) vld_p2 <= vld_p1;
        end
    end

    // Stage p0: key and tag capture
    always_ff @(posedge clock) begin
        if (en_p0) begin
            key_p0 <= in_key;
            tag_p0 <= in_tag;
        end
    end

    // Stage p1/p2: tag follows the products through the lanes
    always_ff @(posedge clock) begin
        if (en_p1) begin
            tag_p1 <= tag_p0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_p2 <= '0;
        end else if (en_p2) begin
            tag_p2 <= tag_p1;
        end
    end

    // Seeds only change with the pipe empty, so in-flight keys never see a
    // mix of old and new seeds; bit 0 is forced high to keep them odd.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_HASHES; i++) begin
                seed_q[i] <= DEFAULT_SEEDS[i][KEY_WIDTH-1:0];
            end
        end else if (seed_we && seed_ready) begin
            for (int i = 0; i < NUM_HASHES; i++) begin
                if (32'(seed_idx) == i) begin
                    seed_q[i] <= seed_data | KEY_WIDTH'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_HASHES; i++) begin : g_lane
        mult_shift_hash #(
            .KEY_WIDTH  (KEY_WIDTH),
            .HASH_WIDTH (HASH_WIDTH)
        ) u_lane (
            .clock   (clock),
            .reset   (reset),
            .en_p1   (en_p1),
            .en_p2   (en_p2),
            .key_p0  (key_p0),
            .seed    (seed_q[i]),
            .hash_p2 (out_hash[i*HASH_WIDTH +: HASH_WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_hash_pipe.sv
// Scoreboard bench for multi_hash_pipe at default parameters, driven with
// hand-computed multiply-shift vectors.
`timescale 1ns/1ps
module tb_multi_hash_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_key = '0;
    logic [7:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_hash;
    logic [7:0]  out_tag;
    logic        seed_we = 1'b0;
    logic [0:0]  seed_idx = '0;
    logic [31:0] seed_data = '0;
    logic        seed_ready;

    multi_hash_pipe dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_key     (in_key),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hash   (out_hash),
        .out_tag    (out_tag),
        .seed_we    (seed_we),
        .seed_idx   (seed_idx),
        .seed_data  (seed_data),
        .seed_ready (seed_ready)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] hash;
        logic [7:0]  tag;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic        stall_q = 1'b0;
    logic [15:0] hold_hash = '0;
    logic [7:0]  hold_tag = '0;

    // Default seeds 0x9E3779B1 / 0x85EBCA6B; out_hash = {h1, h0}
    logic [31:0] vec_key [8] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h0,
                                 32'hFFFF_FFFF, 32'h0000_0100, 32'h0001_0000};
    logic [15:0] vec_exp [8] = '{16'h859E, 16'h0B3C, 16'h91DA, 16'h1778, 16'h0000,
                                 16'h7A61, 16'hEB37, 16'hCA79};

    always @(posedge clock) cyc++;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_out", {out_tag, out_hash}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check({out_tag, out_hash} === {mon_e.tag, mon_e.hash}, "result",
                      {out_tag, out_hash}, {mon_e.tag, mon_e.hash});
            end
        end
        if (out_valid && !out_ready) begin
            check(in_ready == 1'b0, "in_ready_stall", in_ready, 0);
            if (stall_q) begin
                check(out_hash === hold_hash && out_tag === hold_tag, "hold_stable",
                      {out_tag, out_hash}, {hold_tag, hold_hash});
            end
            hold_hash = out_hash;
            hold_tag  = out_tag;
        end
        stall_q = out_valid && !out_ready;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] key, input logic [7:0] tag, input logic [15:0] exp_hash);
        int waited = 0;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_key   = key;
        in_tag   = tag;
        while (!ok && waited < 100) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
            else waited++;
        end
        if (ok) begin
            @(posedge clock);
            exp_q.push_back('{hash: exp_hash, tag: tag});
            #1;
        end else begin
            check(1'b0, "accept_timeout", waited, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic write_seed(input logic [0:0] idx, input logic [31:0] data);
        seed_we   = 1'b1;
        seed_idx  = idx;
        seed_data = data;
        @(posedge clock);
        #1;
        seed_we = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clock);
            #1;
            t++;
        end
        check(exp_q.size() == 0, "drain", exp_q.size(), 0);
        wait_cycles(2);
    endtask

    task automatic check_reset_state();
        check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        check(seed_ready == 1'b1, "rst_seed_ready", seed_ready, 1);
        check(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
        check(out_hash == 16'h0, "rst_out_hash", out_hash, 0);
        check(out_tag == 8'h0, "rst_out_tag", out_tag, 0);
    endtask

    initial begin
        int t0;
        wait_cycles(3);
        reset = 1'b0;
        check_reset_state();

        // Single key latency
        send(32'h1, 8'hA1, 16'h859E);
        check(out_valid == 1'b0, "latency_c1", out_valid, 0);
        wait_cycles(1);
        check(out_valid == 1'b0, "latency_c2", out_valid, 0);
        wait_cycles(1);
        check(out_valid == 1'b1, "latency_c3", out_valid, 1);
        check(out_hash == 16'h859E, "latency_hash", out_hash, 16'h859E);
        drain();

        // Back-to-back keys 1,2,3
        t0 = cyc;
        for (int i = 0; i < 3; i++) send(vec_key[i], 8'h01 + 8'(i), vec_exp[i]);
        check(cyc - t0 == 3, "throughput", cyc - t0, 3);
        drain();

        // Continuous stream with a 5-cycle output stall
        fork
            begin
                for (int i = 0; i < 8; i++) send(vec_key[i], 8'h10 + 8'(i), vec_exp[i]);
            end
            begin
                wait_cycles(3);
                out_ready = 1'b0;
                wait_cycles(5);
                out_ready = 1'b1;
            end
        join
        drain();

        // Seed write with bit 0 forced: seed0 becomes 0x11
        check(seed_ready == 1'b1, "seed_ready_idle", seed_ready, 1);
        write_seed(1'b0, 32'h0000_0010);
        send(32'h0100_0000, 8'h40, 16'h6B11);
        send(32'h0000_0001, 8'h41, 16'h8500);
        drain();

        // Seed write while a key is in flight is ignored
        send(32'h0100_0000, 8'h50, 16'h6B11);
        check(seed_ready == 1'b0, "seed_ready_busy", seed_ready, 0);
        write_seed(1'b1, 32'h0000_0000);
        drain();
        send(32'h0100_0000, 8'h51, 16'h6B11);
        drain();

        // Seed write alongside in_valid wins; the key waits a cycle
        in_valid  = 1'b1;
        in_key    = 32'h0100_0000;
        in_tag    = 8'h60;
        seed_we   = 1'b1;
        seed_idx  = 1'b1;
        seed_data = 32'h0000_0002;
        @(negedge clock);
        check(in_ready == 1'b0, "in_ready_seed_we", in_ready, 0);
        check(seed_ready == 1'b1, "seed_ready_with_key", seed_ready, 1);
        @(posedge clock);
        #1;
        seed_we = 1'b0;
        send(32'h0100_0000, 8'h61, 16'h0311);
        drain();

        // Reset with three keys held in the pipe
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(vec_key[i], 8'h70 + 8'(i), vec_exp[i]);
        check(seed_ready == 1'b0, "seed_ready_full", seed_ready, 0);
        reset = 1'b1;
        exp_q.delete();
        wait_cycles(1);
        reset = 1'b0;
        check_reset_state();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_cycles(1);
            check(out_valid == 1'b0, "no_out_after_reset", out_valid, 0);
        end
        send(32'h0100_0000, 8'h80, 16'h6BB1);
        send(32'h0000_0001, 8'h81, 16'h859E);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
